cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//   Arbiter for the Common Data Bus (CDB).
//   - Several functional units (add/sub, mul/div, load) each present one result: reservation-station tag plus 16-bit value.
//   - Each unit has a one-entry holding buffer; one buffered result per cycle is granted round-robin and broadcast.
//   - Broadcast goes on the registered CDB triple teveEscritaCDB/nameCDB/dadoCDB.
//   - Consumers of the broadcast: reservation stations and the register status table.
// PARAMETERS
//   NUM_UNITS  3   number of requesting functional units (2..8)
//   TAG_W      3   reservation-station tag width; tag 0 = "no producer", never broadcast
//   DATA_W     16  result width
// PORTS
//   clock           in   1               single clock, rising edge
//   reset_n         in   1               asynchronous, active-low reset
//   req_valid       in   NUM_UNITS       unit i offers a result this cycle
//   req_tag         in   NUM_UNITS*TAG_W unit i tag, slice [i*TAG_W +: TAG_W]
//   req_data        in   NUM_UNITS*DATA_W unit i value, slice [i*DATA_W +: DATA_W]
//   req_ready       out  NUM_UNITS       unit i buffer can accept this cycle (combinational)
//   teveEscritaCDB  out  1               CDB broadcast valid (registered)
//   nameCDB         out  TAG_W           broadcast tag (registered)
//   dadoCDB         out  DATA_W          broadcast value (registered)
//   pending         out  NUM_UNITS       holding-buffer full flags
//   err_tag_zero    out  1               sticky: a request carried tag 0
// BEHAVIOUR
//   Reset (reset_n=0, asynchronous):
//     - pending=0, round-robin pointer ptr=0.
//     - teveEscritaCDB=0, nameCDB=0, dadoCDB=0, err_tag_zero=0.
//     - Assert mid-operation: all buffered results are discarded; no broadcast on the first edge after release.
//   Grant (combinational):
//     - g = first index with pending=1, scanning ptr, ptr+1, ... mod NUM_UNITS.
//     - grant vector is one-hot, or zero when pending==0.
//   Ready:
//     - req_ready[i] = ~pending[i] | grant[i].
//     - A unit therefore sustains 1 result/cycle while it alone holds the bus.
//   Accept: on a rising edge with req_valid[i] & req_ready[i]:
//     - tag!=0: buffer i <= {tag, data}; pending[i] <= 1.
//     - tag==0: result dropped, pending[i] unchanged by this request, err_tag_zero <= 1 (cleared only by reset).
//   Broadcast: on each rising edge with pending!=0:
//     - teveEscritaCDB <= 1; nameCDB/dadoCDB <= buffer g.
//     - ptr <= (g+1) mod NUM_UNITS.
//     - pending[g] <= 0, unless unit g is refilled on the same edge; then it stays 1 with the new contents.
//   Idle: on an edge with pending==0:
//     - teveEscritaCDB <= 0; nameCDB <= 0; dadoCDB <= 0; ptr unchanged.
//   Latency: req_valid in cycle 0 into an empty buffer with no competition -> teveEscritaCDB=1 with that tag/data in cycle 2.
//   Throughput: at most one broadcast per cycle total.
//   Fairness: with all units continuously pending, each unit waits at most NUM_UNITS-1 broadcasts between grants.
//   Back-pressure: a unit holding req_valid while req_ready=0 must keep tag/data stable; not accepted until ready.
//   Simultaneous events: all units may be accepted on the same edge that one buffer is granted; buffers are independent.
// TESTING
//   T1 single: reset, unit0 valid tag=1 data=16'h0005 in cycle 0 -> cycle 2: teveEscritaCDB=1, nameCDB=1, dadoCDB=5; cycle 3: teveEscritaCDB=0.
//   T2 contention: units 0,1,2 valid in the same cycle (tags 1,2,3) with ptr=0 -> broadcasts tags 1,2,3 on consecutive cycles; req_ready[1]=0 and req_ready[2]=0 while waiting.
//   T3 rotation: after T2 (ptr=0), unit1 and unit2 pending together -> unit1 first, then unit2; ptr=0 afterwards.
//   T4 streaming: unit2 alone valid 4 cycles, data 10,11,12,13 -> 4 back-to-back broadcasts, req_ready[2]=1 throughout.
//   T5 tag zero: unit1 valid tag=0 data=16'hBEEF -> no broadcast; err_tag_zero=1 until reset.
//   T6 reset mid-op: two buffers pending, reset_n low 1 cycle -> pending=0, outputs 0, no stale broadcast after release.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// Request/broadcast bundle between the functional units and the CDB arbiter.
// The master side is the units plus CDB consumers; the slave side is the arbiter.
interface cdb_arbiter_if #(
  parameter int NUM_UNITS = 3,
  parameter int TAG_W     = 3,
  parameter int DATA_W    = 16
);
  logic [NUM_UNITS-1:0]        req_valid;
  logic [NUM_UNITS*TAG_W-1:0]  req_tag;
  logic [NUM_UNITS*DATA_W-1:0] req_data;
  logic [NUM_UNITS-1:0]        req_ready;
  logic                        teveEscritaCDB;
  logic [TAG_W-1:0]            nameCDB;
  logic [DATA_W-1:0]           dadoCDB;
  logic [NUM_UNITS-1:0]        pending;
  logic                        err_tag_zero;

  modport master (
    output req_valid, req_tag, req_data,
    input  req_ready, teveEscritaCDB, nameCDB, dadoCDB, pending, err_tag_zero
  );

  modport slave (
    input  req_valid, req_tag, req_data,
    output req_ready, teveEscritaCDB, nameCDB, dadoCDB, pending, err_tag_zero
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one holding buffer per functional unit, round-robin
// grant among full buffers, one registered broadcast per cycle.

module cdb_slot #(
  parameter int TAG_W  = 3,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic [DATA_W-1:0] req_data,
  input  logic              grant,
  output logic              ready,
  output logic              pend,
  output logic [TAG_W-1:0]  tag,
  output logic [DATA_W-1:0] data,
  output logic              tag_zero
);
  logic accept;

  // A granted buffer drains this edge, so it can take a new result at once.
  assign ready    = ~pend | grant;
  assign accept   = req_valid & ready;
  assign tag_zero = accept & (req_tag == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend <= 1'b0;
      tag  <= '0;
      data <= '0;
    end else if (accept && req_tag != '0) begin
      pend <= 1'b1;
      tag  <= req_tag;
      data <= req_data;
    end else if (grant) begin
      pend <= 1'b0;
    end
  end
endmodule

module cdb_arbiter #(
  parameter int NUM_UNITS = 3,
  parameter int TAG_W     = 3,
  parameter int DATA_W    = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  cdb_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_UNITS);

  logic [NUM_UNITS-1:0]             grant, rdy, pend, tz;
  logic [NUM_UNITS-1:0][TAG_W-1:0]  slot_tag;
  logic [NUM_UNITS-1:0][DATA_W-1:0] slot_data;
  logic [PTR_W-1:0]                 ptr, gnt_idx;
  logic [PTR_W:0]                   scan;
  logic                             found;
  logic                             teve_q, err_q;
  logic [TAG_W-1:0]                 name_q;
  logic [DATA_W-1:0]                dado_q;

  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_slot
    cdb_slot #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_slot (
      .clock    (clock),
      .reset_n  (reset_n),
      .req_valid(bus.req_valid[i]),
      .req_tag  (bus.req_tag[i*TAG_W +: TAG_W]),
      .req_data (bus.req_data[i*DATA_W +: DATA_W]),
      .grant    (grant[i]),
      .ready    (rdy[i]),
      .pend     (pend[i]),
      .tag      (slot_tag[i]),
      .data     (slot_data[i]),
      .tag_zero (tz[i])
    );
  end

  // Scan from ptr with wrap; first full buffer wins.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    scan    = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      scan = {1'b0, ptr} + (PTR_W+1)'(k);
      if (scan >= (PTR_W+1)'(NUM_UNITS))
        scan = scan - (PTR_W+1)'(NUM_UNITS);
      if (!found && pend[scan[PTR_W-1:0]]) begin
        found                    = 1'b1;
        gnt_idx                  = scan[PTR_W-1:0];
        grant[scan[PTR_W-1:0]]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr    <= '0;
      teve_q <= 1'b0;
      name_q <= '0;
      dado_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= err_q | (|tz);
      if (found) begin
        teve_q <= 1'b1;
        name_q <= slot_tag[gnt_idx];
        dado_q <= slot_data[gnt_idx];
        ptr    <= (gnt_idx == PTR_W'(NUM_UNITS-1)) ? '0 : gnt_idx + 1'b1;
      end else begin
        teve_q <= 1'b0;
        name_q <= '0;
        dado_q <= '0;
      end
    end
  end

  assign bus.req_ready      = rdy;
  assign bus.pending        = pend;
  assign bus.teveEscritaCDB = teve_q;
  assign bus.nameCDB        = name_q;
  assign bus.dadoCDB        = dado_q;
  assign bus.err_tag_zero   = err_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a queue-level model checked every cycle,
// plus literal expectations for the single, contention, rotation, streaming,
// tag-zero and mid-operation reset scenarios.
module tb_cdb_arbiter;
  localparam int N      = 3;
  localparam int TAG_W  = 3;
  localparam int DATA_W = 16;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  cdb_arbiter_if #(.NUM_UNITS(N), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

  cdb_arbiter #(.NUM_UNITS(N), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  // Model state: per-unit buffer contents and full flag, rotating start point.
  bit m_pend [N];
  int m_tag  [N];
  int m_data [N];
  int m_ptr;
  bit m_teve;
  int m_name, m_dado;
  bit m_err;

  function automatic int m_grant();
    for (int k = 0; k < N; k++)
      if (m_pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic bit m_ready(int u);
    return !m_pend[u] || (m_grant() == u);
  endfunction

  function automatic int in_tag(int u);
    return int'(bus.req_tag[u*TAG_W +: TAG_W]);
  endfunction

  function automatic int in_data(int u);
    return int'(bus.req_data[u*DATA_W +: DATA_W]);
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] <= 1'b0;
        m_tag[i]  <= 0;
        m_data[i] <= 0;
      end
      m_ptr  <= 0;
      m_teve <= 1'b0;
      m_name <= 0;
      m_dado <= 0;
      m_err  <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] && m_ready(i) && in_tag(i) != 0) begin
          m_pend[i] <= 1'b1;
          m_tag[i]  <= in_tag(i);
          m_data[i] <= in_data(i);
        end else if (m_grant() == i) begin
          m_pend[i] <= 1'b0;
        end
        if (bus.req_valid[i] && m_ready(i) && in_tag(i) == 0) m_err <= 1'b1;
      end
      if (m_grant() >= 0) begin
        m_teve <= 1'b1;
        m_name <= m_tag[m_grant()];
        m_dado <= m_data[m_grant()];
        m_ptr  <= (m_grant() + 1) % N;
      end else begin
        m_teve <= 1'b0;
        m_name <= 0;
        m_dado <= 0;
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    for (int i = 0; i < N; i++) begin
      chk("model_ready", 32'(bus.req_ready[i]), 32'(m_ready(i)));
      chk("model_pending", 32'(bus.pending[i]), 32'(m_pend[i]));
    end
    chk("model_teve", 32'(bus.teveEscritaCDB), 32'(m_teve));
    chk("model_name", 32'(bus.nameCDB), m_name);
    chk("model_dado", 32'(bus.dadoCDB), m_dado);
    chk("model_err", 32'(bus.err_tag_zero), 32'(m_err));
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic set_req(int u, int tag, int data);
    bus.req_valid[u] = 1'b1;
    bus.req_tag[u*TAG_W +: TAG_W] = TAG_W'(tag);
    bus.req_data[u*DATA_W +: DATA_W] = DATA_W'(data);
  endtask

  task automatic clr_req();
    bus.req_valid = '0;
    bus.req_tag   = '0;
    bus.req_data  = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    clr_req();
    step();
    step();
    chk("rst_teve", 32'(bus.teveEscritaCDB), 32'd0);
    chk("rst_name", 32'(bus.nameCDB), 32'd0);
    chk("rst_pending", 32'(bus.pending), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'b111);
    chk("rst_err", 32'(bus.err_tag_zero), 32'd0);
    reset_n = 1'b1;

    // T1 single result, two-cycle latency
    set_req(0, 1, 16'h0005);
    step(); clr_req();
    chk("t1_pend", 32'(bus.pending), 32'b001);
    chk("t1_teve_c1", 32'(bus.teveEscritaCDB), 32'd0);
    step();
    chk("t1_teve_c2", 32'(bus.teveEscritaCDB), 32'd1);
    chk("t1_name", 32'(bus.nameCDB), 32'd1);
    chk("t1_dado", 32'(bus.dadoCDB), 32'h5);
    step();
    chk("t1_teve_c3", 32'(bus.teveEscritaCDB), 32'd0);

    // T2 contention from ptr=0
    do_reset();
    set_req(0, 1, 16'h11); set_req(1, 2, 16'h22); set_req(2, 3, 16'h33);
    step(); clr_req();
    chk("t2_pend", 32'(bus.pending), 32'b111);
    chk("t2_ready_a", 32'(bus.req_ready), 32'b001);
    step();
    chk("t2_name1", 32'(bus.nameCDB), 32'd1);
    chk("t2_ready_b", 32'(bus.req_ready), 32'b011);
    step();
    chk("t2_name2", 32'(bus.nameCDB), 32'd2);
    chk("t2_dado2", 32'(bus.dadoCDB), 32'h22);
    step();
    chk("t2_name3", 32'(bus.nameCDB), 32'd3);
    step();
    chk("t2_idle", 32'(bus.teveEscritaCDB), 32'd0);

    // T3 rotation, then prove ptr wrapped to 0
    set_req(1, 4, 16'h44); set_req(2, 5, 16'h55);
    step(); clr_req();
    step();
    chk("t3_first", 32'(bus.nameCDB), 32'd4);
    step();
    chk("t3_second", 32'(bus.nameCDB), 32'd5);
    step();
    chk("t3_idle", 32'(bus.teveEscritaCDB), 32'd0);
    set_req(0, 1, 16'h7); set_req(2, 6, 16'h66);
    step(); clr_req();
    step();
    chk("t3_ptr0", 32'(bus.nameCDB), 32'd1);
    step();
    chk("t3_ptr0_next", 32'(bus.nameCDB), 32'd6);
    step();

    // T4 streaming from a single unit
    for (int k = 0; k < 4; k++) begin
      set_req(2, 6, 10 + k);
      chk("t4_ready", 32'(bus.req_ready[2]), 32'd1);
      step();
      if (k >= 1) begin
        chk("t4_teve", 32'(bus.teveEscritaCDB), 32'd1);
        chk("t4_dado", 32'(bus.dadoCDB), 32'(10 + k - 1));
      end
    end
    clr_req();
    step();
    chk("t4_last", 32'(bus.dadoCDB), 32'd13);
    step();
    chk("t4_idle", 32'(bus.teveEscritaCDB), 32'd0);

    // T5 tag zero is dropped and latched as an error
    set_req(1, 0, 16'hBEEF);
    step(); clr_req();
    chk("t5_err", 32'(bus.err_tag_zero), 32'd1);
    chk("t5_pend", 32'(bus.pending), 32'd0);
    step();
    chk("t5_nobcast", 32'(bus.teveEscritaCDB), 32'd0);
    step();
    chk("t5_sticky", 32'(bus.err_tag_zero), 32'd1);

    // T6 asynchronous reset with two buffers still full
    set_req(0, 1, 16'h1); set_req(1, 2, 16'h2); set_req(2, 3, 16'h3);
    step(); clr_req();
    step();
    chk("t6_pre_teve", 32'(bus.teveEscritaCDB), 32'd1);
    chk("t6_pre_pend", 32'(bus.pending), 32'b110);
    reset_n = 1'b0;
    #1;
    chk("t6_pend", 32'(bus.pending), 32'd0);
    chk("t6_teve", 32'(bus.teveEscritaCDB), 32'd0);
    chk("t6_name", 32'(bus.nameCDB), 32'd0);
    chk("t6_dado", 32'(bus.dadoCDB), 32'd0);
    chk("t6_err", 32'(bus.err_tag_zero), 32'd0);
    step();
    reset_n = 1'b1;
    step();
    chk("t6_no_stale", 32'(bus.teveEscritaCDB), 32'd0);
    step();
    chk("t6_no_stale2", 32'(bus.teveEscritaCDB), 32'd0);
    chk("t6_pend_after", 32'(bus.pending), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
